// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the common-data-bus arbiter.
// Optional feature macro: CDB_BYPASS_EN (same-cycle bypass into the bus).
package cdb_arbiter_pkg;

  localparam int N_REQ         = 3;
  localparam int ROB_WIDTH_BIT = 4;
  localparam int DATA_W        = 32;
  localparam int SRC_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Producer indices on the request ports and on cdb_src.
  localparam logic [SRC_W-1:0] CDB_SRC_ALU = SRC_W'(0);
  localparam logic [SRC_W-1:0] CDB_SRC_LSB = SRC_W'(1);
  localparam logic [SRC_W-1:0] CDB_SRC_BR  = SRC_W'(2);

  // One buffered or forwarded result.
  typedef struct packed {
    logic [ROB_WIDTH_BIT-1:0] rob_id;
    logic [DATA_W-1:0]        val;
  } cdb_entry_t;

  // Round-robin pointer successor: the producer after the winner gets first look.
  function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] idx);
    if (idx == SRC_W'(N_REQ - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// N-way round-robin priority encoder: scans cand starting at rr_ptr and
// returns the first set position as one-hot grant plus binary index.
module rr_picker #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     cand,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Position visited at scan step off, wrapping around the producer ring.
  function automatic int ring_pos(input int base, input int off);
    return (base + off) % N;
  endfunction

  // First candidate at or after rr_ptr wins; later candidates are masked by any.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && cand[ring_pos(int'(rr_ptr), k)]) begin
        grant[ring_pos(int'(rr_ptr), k)] = 1'b1;
        idx = IDX_W'(ring_pos(int'(rr_ptr), k));
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding buffer per producer, round-robin
// pick of one buffered result per cycle, registered onto the bus.
// Optional feature macro: CDB_BYPASS_EN lets a granted producer with an empty
// buffer drive the bus registers directly (1-edge latency instead of 2).
//
// Handshake: producer i's result transfers on a rising edge where
// req_valid[i] && req_ready[i]; req_ready never depends on req_valid. The bus
// side has no back-pressure: cdb_valid is a one-cycle pulse per result and is
// only meaningful on cycles where rdy_in is high.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic                            clear_in,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [N_REQ*ROB_WIDTH_BIT-1:0]  req_rob_id,
  input  logic [N_REQ*DATA_W-1:0]         req_val,
  output logic [N_REQ-1:0]                req_ready,
  output logic                            cdb_valid,
  output logic [ROB_WIDTH_BIT-1:0]        cdb_rob_id,
  output logic [DATA_W-1:0]               cdb_val,
  output logic [SRC_W-1:0]                cdb_src
);

  logic [N_REQ-1:0] buf_valid;
  cdb_entry_t       buf_q [N_REQ];
  logic [SRC_W-1:0] rr_ptr;

  cdb_entry_t       req_entry [N_REQ];
  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] grant;
  logic [SRC_W-1:0] win_idx;
  logic             win_any;
  cdb_entry_t       win_entry;
  logic             advance;
  logic [N_REQ-1:0] load;

  // Split the flat request buses into per-producer entries.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_entry[i].rob_id = req_rob_id[i*ROB_WIDTH_BIT +: ROB_WIDTH_BIT];
      req_entry[i].val    = req_val[i*DATA_W +: DATA_W];
    end
  end

`ifdef CDB_BYPASS_EN
  // An incoming result competes in the same cycle it arrives.
  assign cand = buf_valid | req_valid;
`else
  // Only buffered results compete; arrivals wait one edge in the buffer.
  assign cand = buf_valid;
`endif

  rr_picker #(
    .N     (N_REQ),
    .IDX_W (SRC_W)
  ) u_picker (
    .cand   (cand),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .idx    (win_idx),
    .any    (win_any)
  );

  // State moves only on a ready, non-flush edge.
  assign advance   = rdy_in && !clear_in;
  // A producer may hand over when its buffer is empty or is draining this edge.
  assign req_ready = {N_REQ{advance}} & (~buf_valid | grant);
  // A granted producer with an empty buffer is a bypass and is not captured.
  assign load      = req_valid & req_ready & ~(grant & ~buf_valid);

  // Select the winner's result; an empty granted buffer means the input bypasses.
  always_comb begin
    win_entry = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
`ifdef CDB_BYPASS_EN
        win_entry = buf_valid[i] ? buf_q[i] : req_entry[i];
`else
        win_entry = buf_q[i];
`endif
      end
    end
  end

  // Bus registers and round-robin pointer.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_val    <= '0;
      cdb_src    <= '0;
      rr_ptr     <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        cdb_valid <= 1'b0;
        rr_ptr    <= '0;
      end else if (win_any) begin
        cdb_valid  <= 1'b1;
        cdb_rob_id <= win_entry.rob_id;
        cdb_val    <= win_entry.val;
        cdb_src    <= win_idx;
        rr_ptr     <= rr_next(win_idx);
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

  // Per-producer holding buffers: capture on handshake, empty on grant.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      buf_valid <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        buf_q[i] <= '0;
      end
    end else if (rdy_in) begin
      if (clear_in) begin
        buf_valid <= '0;
      end else begin
        for (int i = 0; i < N_REQ; i++) begin
          if (load[i]) begin
            buf_valid[i] <= 1'b1;
            buf_q[i]     <= req_entry[i];
          end else if (grant[i]) begin
            buf_valid[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin scheduler that shares the single result (common data) bus into the reorder buffer among N execution-side producers: ALU reservation station, load/store buffer and branch unit.
- Each producer has a one-entry holding buffer, so it can complete without waiting for a grant.
- One winner per cycle is registered onto the bus that drives the reorder buffer's set port and the wakeup logic.
- Flushed by the reorder buffer's mispredict clear.

Parameters:
N_REQ, 3, number of producers (index 0 = ALU, 1 = LSB, 2 = branch)
ROB_WIDTH_BIT, 4, reorder-buffer index width
DATA_W, 32, result width

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global ready; low freezes all state
clear_in  in  1  mispredict flush from the reorder buffer
req_valid  in  N_REQ  producer i presents a result
req_rob_id  in  N_REQ*ROB_WIDTH_BIT  destination entry, slice i
req_val  in  N_REQ*DATA_W  result value, slice i
req_ready  out  N_REQ  producer i's result is accepted this cycle
cdb_valid  out  1  bus carries a result (registered)
cdb_rob_id  out  ROB_WIDTH_BIT  entry being set (registered)
cdb_val  out  DATA_W  value (registered)
cdb_src  out  $clog2(N_REQ)  index of the winning producer (registered)

Behaviour:
- Reset (rst_in=0, async): all buf_valid=0, rr_ptr=0; cdb_valid=0, cdb_rob_id=0, cdb_val=0, cdb_src=0.
- State per producer: buf_valid, buf_rob_id, buf_val. Arbiter state: rr_ptr.
- Candidates: cand[i] = buf_valid[i].
- Grant: first i in order rr_ptr, rr_ptr+1, ... (mod N_REQ) with cand[i]=1; this is one-hot grant[i].
- req_ready[i] (combinational) = rdy_in && !clear_in && (!buf_valid[i] || grant[i]).
- On an edge with rdy_in=1 and clear_in=0:
  - If any grant: cdb_valid<=1, cdb_rob_id/cdb_val/cdb_src <= winner's buffer contents, rr_ptr <= (winner+1) mod N_REQ. Otherwise cdb_valid<=0; other cdb fields hold; rr_ptr holds.
  - For each i: if req_valid[i] && req_ready[i], then buf <= input and buf_valid<=1.
  - Else if grant[i], then buf_valid[i]<=0.
  - Else the buffer holds.
- Latency: result accepted at edge E appears on the bus in the cycle after edge E+1 at the earliest. Sustained throughput is 1 result/cycle per producer when that producer is granted every cycle.
- Starvation bound: a buffered result waits at most N_REQ-1 grant cycles.
- Flush (clear_in=1 and rdy_in=1 at edge): all buf_valid<=0, cdb_valid<=0, rr_ptr<=0. Inputs in that cycle are dropped and req_ready=0.
- rdy_in=0: nothing changes, req_ready=0, cdb outputs hold their values. Consumers of cdb_valid already gate on rdy_in.
- Same rob_id from two producers: not checked. Both are forwarded in grant order.
- Reset asserted mid-operation: immediate clear regardless of rdy_in.

Optional Feature:
- Macro CDB_BYPASS_EN.
- Defined:
  - cand[i] = buf_valid[i] || req_valid[i]; priority is unchanged.
  - If the winner's buffer is empty, the incoming result goes straight to the cdb registers and is not buffered. This gives 1-edge latency.
  - req_ready[i] = rdy_in && !clear_in && (!buf_valid[i] || grant[i]).
  - When the buffer is valid and granted, a same-cycle input refills the buffer.
- Undefined: the behaviour above, with 2-edge latency.

Decomposition:
- Shared package/const header: ROB_WIDTH_BIT, DATA_W, producer index constants (CDB_SRC_ALU=0, CDB_SRC_LSB=1, CDB_SRC_BR=2).
- One sub-module: rr_picker (N-way round-robin priority encoder: inputs cand and rr_ptr; outputs one-hot grant, binary index, any).

Test Plan:
1. Single producer: reset, then req_valid=001 with rob_id=5, val=0xDEAD for one cycle, then idle. Required: cdb_valid=1, rob_id=5, val=0xDEAD, src=0 exactly one cycle, 2 edges later; rr_ptr=1.
2. All three valid with rob_ids 1, 2, 3 in the same cycle, then idle. Required: bus order 1, 2, 3 on consecutive cycles; req_ready=111 in the first cycle; rr_ptr returns to 0.
3. Producer 0 continuously valid, producers 1 and 2 each pulse once. Required: grant sequence 0, 1, 2, 0, ... with no result waiting more than 2 grant cycles.
4. Back-pressure: hold producer 1 and 2 buffers full while a new req_valid[1] is asserted. Required: req_ready[1]=0 until buffer 1 is granted; no value is lost or duplicated.
5. Flush: buffers hold rob_ids 4 and 6; assert clear_in for one cycle. Required: cdb_valid=0 the next cycle, neither 4 nor 6 is ever emitted, rr_ptr=0.
6. rdy_in=0 for 3 cycles with buffered results, then async reset pulse. Required: outputs frozen during the stall; all outputs 0 immediately on rst_in=0. With CDB_BYPASS_EN, case 1 latency is 1 edge.
